// File: rtl/activation_loader_pkg.sv
// Precision codes, lane/word helpers and loader state encoding
// shared by the activation loader and its lane unpacker.
package activation_loader_pkg;

    localparam int LOG_ALLOWED_PRECISIONS = 3;

    typedef logic [LOG_ALLOWED_PRECISIONS-1:0] prec_t;

    localparam prec_t NO_COMPUTATION = 3'd0;
    localparam prec_t INT8           = 3'd1;
    localparam prec_t INT16          = 3'd2;
    localparam prec_t INT32          = 3'd3;
    localparam prec_t INT64          = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CAPT = 2'd2,
        S_FULL = 2'd3
    } load_state_e;

    function automatic int prec_bits(prec_t code);
        case (code)
            INT8:    return 8;
            INT16:   return 16;
            INT32:   return 32;
            INT64:   return 64;
            default: return 0;
        endcase
    endfunction

    function automatic bit prec_valid(prec_t code);
        return prec_bits(code) != 0;
    endfunction

    function automatic int lanes_per_word(prec_t code, int fifo_w);
        int p;
        p = prec_bits(code);
        return (p == 0) ? 0 : fifo_w / p;
    endfunction

    // Words needed to fill all rows; at least one for any legal precision.
    function automatic int words_needed(prec_t code, int fifo_w, int rows);
        int l;
        l = lanes_per_word(code, fifo_w);
        return (l == 0) ? 1 : (rows + l - 1) / l;
    endfunction

endpackage

// File: rtl/activation_loader_lane_unpack.sv
// Slices one FIFO word into sign-extended activation rows starting
// at a base row, with a write-enable per row that the word covers.
module act_lane_unpack
    import activation_loader_pkg::*;
#(
    parameter int ROWS               = 4,
    parameter int DATA_WIDTH_FIFO_IN = 64,
    parameter int DATA_WIDTH_MAC     = 64,
    parameter int BASE_W             = 3
) (
    input  logic [DATA_WIDTH_FIFO_IN-1:0]  word,
    input  prec_t                          prec,
    input  logic [BASE_W-1:0]              base_row,
    output logic [ROWS*DATA_WIDTH_MAC-1:0] rows,
    output logic [ROWS-1:0]                row_we
);

    localparam int DW = DATA_WIDTH_MAC;

    // Pick each row's lane out of the word and sign-extend it.
    always_comb begin
        int p;
        int l;
        int lane;
        logic [DATA_WIDTH_FIFO_IN-1:0] shifted;
        rows    = '0;
        row_we  = '0;
        shifted = '0;
        p = prec_bits(prec);
        l = lanes_per_word(prec, DATA_WIDTH_FIFO_IN);
        for (int r = 0; r < ROWS; r++) begin
            lane = r - int'(base_row);
            if (lane >= 0 && lane < l) begin
                shifted   = word >> (lane * p);
                row_we[r] = 1'b1;
                case (prec)
                    INT8:    rows[r*DW +: DW] = DW'($signed(shifted[7:0]));
                    INT16:   rows[r*DW +: DW] = DW'($signed(shifted[15:0]));
                    INT32:   rows[r*DW +: DW] = DW'($signed(shifted[31:0]));
                    INT64:   rows[r*DW +: DW] = DW'($signed(shifted[63:0]));
                    default: row_we[r] = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: rtl/activation_loader.sv
// Pulls packed activation words from the input FIFO and assembles a
// ROWS-wide sign-extended vector for the MXU, held until consumed.
module activation_loader
    import activation_loader_pkg::*;
#(
    parameter int ROWS               = 4,
    parameter int DATA_WIDTH_FIFO_IN = 64,
    parameter int DATA_WIDTH_MAC     = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable_load_activation_data,
    input  logic [LOG_ALLOWED_PRECISIONS-1:0] data_precision,
    input  logic                              flush,
    input  logic                              infifo_is_empty,
    output logic                              infifo_read,
    input  logic [DATA_WIDTH_FIFO_IN-1:0]     infifo_dout,
    output logic [ROWS*DATA_WIDTH_MAC-1:0]    act_out,
    output logic                              act_valid,
    input  logic                              act_consume,
    output logic                              busy,
    output logic                              error
);

    localparam int DW     = DATA_WIDTH_MAC;
    localparam int CNT_W  = $clog2(ROWS + 1);
    localparam int BASE_W = $clog2(ROWS) + 1;

    load_state_e           state_q, state_d;
    prec_t                 prec_q, prec_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic [ROWS*DW-1:0]    act_q, act_d;
    logic                  error_q, error_d;

    logic [BASE_W-1:0]     base_row;
    logic                  last_word;
    logic [ROWS*DW-1:0]    lane_rows;
    logic [ROWS-1:0]       lane_we;

    // First row covered by the word now arriving, and whether it is the last.
    always_comb begin
        base_row  = BASE_W'(int'(word_cnt_q) *
                    lanes_per_word(prec_q, DATA_WIDTH_FIFO_IN));
        last_word = int'(word_cnt_q) ==
                    words_needed(prec_q, DATA_WIDTH_FIFO_IN, ROWS) - 1;
    end

    act_lane_unpack #(
        .ROWS               (ROWS),
        .DATA_WIDTH_FIFO_IN (DATA_WIDTH_FIFO_IN),
        .DATA_WIDTH_MAC     (DATA_WIDTH_MAC),
        .BASE_W             (BASE_W)
    ) u_unpack (
        .word     (infifo_dout),
        .prec     (prec_q),
        .base_row (base_row),
        .rows     (lane_rows),
        .row_we   (lane_we)
    );

    // Next-state, FIFO pop and row capture; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        prec_d      = prec_q;
        word_cnt_d  = word_cnt_q;
        act_d       = act_q;
        error_d     = 1'b0;
        infifo_read = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (enable_load_activation_data) begin
                        if (prec_valid(data_precision)) begin
                            prec_d     = data_precision;
                            word_cnt_d = '0;
                            state_d    = S_REQ;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    error_d = enable_load_activation_data;
                    if (!infifo_is_empty) begin
                        infifo_read = 1'b1;
                        state_d     = S_CAPT;
                    end
                end
                S_CAPT: begin
                    error_d = enable_load_activation_data;
                    for (int r = 0; r < ROWS; r++) begin
                        if (lane_we[r]) begin
                            act_d[r*DW +: DW] = lane_rows[r*DW +: DW];
                        end
                    end
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    state_d    = last_word ? S_FULL : S_REQ;
                end
                S_FULL: begin
                    if (act_consume) begin
                        state_d = S_IDLE;
                        if (enable_load_activation_data) begin
                            if (prec_valid(data_precision)) begin
                                prec_d     = data_precision;
                                word_cnt_d = '0;
                                state_d    = S_REQ;
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                    end else begin
                        error_d = enable_load_activation_data;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, precision, word counter, vector and error pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            prec_q     <= NO_COMPUTATION;
            word_cnt_q <= '0;
            act_q      <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prec_q     <= prec_d;
            word_cnt_q <= word_cnt_d;
            act_q      <= act_d;
            error_q    <= error_d;
        end
    end

    assign act_out   = act_q;
    assign act_valid = (state_q == S_FULL);
    assign busy      = (state_q != S_IDLE);
    assign error     = error_q;

endmodule

// File: tb/tb_activation_loader.sv
// Directed and randomized checks of the activation loader against
// a lane-arithmetic reference model and a simple FIFO model.
module tb_activation_loader;
    import activation_loader_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable_load_activation_data;
    logic [2:0]   data_precision;
    logic         flush;
    logic         infifo_is_empty;
    logic         infifo_read;
    logic [63:0]  infifo_dout;
    logic [255:0] act_out;
    logic         act_valid;
    logic         act_consume;
    logic         busy;
    logic         error;

    activation_loader #(
        .ROWS               (4),
        .DATA_WIDTH_FIFO_IN (64),
        .DATA_WIDTH_MAC     (64)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .enable_load_activation_data (enable_load_activation_data),
        .data_precision              (data_precision),
        .flush                       (flush),
        .infifo_is_empty             (infifo_is_empty),
        .infifo_read                 (infifo_read),
        .infifo_dout                 (infifo_dout),
        .act_out                     (act_out),
        .act_valid                   (act_valid),
        .act_consume                 (act_consume),
        .busy                        (busy),
        .error                       (error)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int op_start = 0;
    int nreads = 0;
    int err_seen = 0;
    int valid_seen = 0;
    int stall_cfg = 0;
    int stall_left = 0;
    bit first_pop = 0;
    logic [2:0]  cur_prec;
    logic [63:0] fifo_q[$];
    logic [63:0] cur_words[$];

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int bits_of(logic [2:0] code);
        case (code)
            3'd1:    return 8;
            3'd2:    return 16;
            3'd3:    return 32;
            default: return 64;
        endcase
    endfunction

    // Reference: row r = signed field (r%L) of word r/L.
    function automatic logic [255:0] model_vec();
        logic [255:0] v;
        logic [63:0]  f;
        logic [63:0]  m;
        int pb;
        int per;
        v   = '0;
        pb  = bits_of(cur_prec);
        per = 64 / pb;
        for (int r = 0; r < 4; r++) begin
            f = cur_words[r / per] >> ((r % per) * pb);
            if (pb < 64) begin
                m = (64'd1 << pb) - 64'd1;
                f = f & m;
                if (f[pb-1]) f = f | ~m;
            end
            v[r*64 +: 64] = f;
        end
        return v;
    endfunction

    task automatic upd_empty();
        infifo_is_empty = (stall_left > 0) || (fifo_q.size() == 0);
    endtask

    task automatic tick();
        logic rd;
        #3;
        rd = infifo_read;
        if (rd) nreads++;
        if (error) err_seen++;
        if (act_valid) valid_seen++;
        @(posedge clk);
        #1;
        cyc++;
        if (stall_left > 0) stall_left--;
        if (rd) begin
            if (fifo_q.size() > 0) infifo_dout = fifo_q.pop_front();
            if (first_pop && stall_cfg > 0) stall_left = stall_cfg + 1;
            first_pop = 0;
        end
        upd_empty();
    endtask

    task automatic prep_op(logic [2:0] code, int stall);
        cur_prec = code;
        foreach (cur_words[i]) fifo_q.push_back(cur_words[i]);
        stall_cfg  = stall;
        stall_left = 0;
        first_pop  = 1;
        nreads     = 0;
        err_seen   = 0;
        valid_seen = 0;
        op_start   = cyc;
        upd_empty();
    endtask

    task automatic launch();
        enable_load_activation_data = 1'b1;
        data_precision = cur_prec;
        tick();
        enable_load_activation_data = 1'b0;
    endtask

    task automatic finish_op(string tag, int exp_lat, int exp_n, int exp_err);
        int guard;
        guard = 0;
        while (act_valid !== 1'b1 && guard < 300) begin
            tick();
            guard++;
        end
        chk({tag, "_lat"}, cyc - op_start, exp_lat);
        chk({tag, "_rows"}, act_out, model_vec());
        chk({tag, "_reads"}, nreads, exp_n);
        chk({tag, "_err"}, err_seen, exp_err);
    endtask

    task automatic consume_op(string tag);
        act_consume = 1'b1;
        tick();
        act_consume = 1'b0;
        chk({tag, "_vdrop"}, act_valid, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int st;
        int hold;
        logic [2:0] code;
        reset = 1'b0;
        enable_load_activation_data = 1'b0;
        data_precision = 3'd0;
        flush = 1'b0;
        act_consume = 1'b0;
        infifo_is_empty = 1'b1;
        infifo_dout = '0;
        #12;
        chk("rst_act", act_out, '0);
        chk("rst_vld", act_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", error, 1'b0);
        chk("rst_rd", infifo_read, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        act_consume = 1'b1;
        tick();
        act_consume = 1'b0;
        chk("cons_idle_busy", busy, 1'b0);
        chk("cons_idle_vld", act_valid, 1'b0);

        cur_words = '{64'h8001_7FFF_FFFE_0003};
        prep_op(INT16, 0);
        launch();
        finish_op("int16", 3, 1, 0);
        consume_op("int16");

        cur_words = '{64'h8000_0000_0000_0005, 64'h0000_0001_FFFF_FFFF};
        prep_op(INT32, 0);
        launch();
        finish_op("int32", 5, 2, 0);
        consume_op("int32");

        cur_words = '{64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF};
        prep_op(INT64, 3);
        launch();
        finish_op("int64_stall", 12, 4, 0);
        consume_op("int64_stall");

        fifo_q.push_back(64'h1111);
        upd_empty();
        enable_load_activation_data = 1'b1;
        data_precision = NO_COMPUTATION;
        tick();
        enable_load_activation_data = 1'b0;
        chk("badprec_err", error, 1'b1);
        chk("badprec_busy", busy, 1'b0);
        chk("badprec_rd", infifo_read, 1'b0);
        tick();
        chk("badprec_pulse", error, 1'b0);
        fifo_q.delete();
        upd_empty();

        cur_words = '{64'h1234_8765_0F0F_F0F0};
        prep_op(INT16, 0);
        launch();
        enable_load_activation_data = 1'b1;
        data_precision = INT8;
        tick();
        enable_load_activation_data = 1'b0;
        chk("busy_start_err", error, 1'b1);
        finish_op("busy_start", 3, 1, 1);
        consume_op("busy_start");

        cur_words = '{64'h80FF_7F01_C0DE_F00D};
        prep_op(INT8, 0);
        launch();
        finish_op("int8", 3, 1, 0);
        cur_words = '{64'hFFFF_0001_8000_7FFF};
        prep_op(INT16, 0);
        act_consume = 1'b1;
        enable_load_activation_data = 1'b1;
        data_precision = INT16;
        tick();
        act_consume = 1'b0;
        enable_load_activation_data = 1'b0;
        chk("b2b_vdrop", act_valid, 1'b0);
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_err", error, 1'b0);
        #1;
        chk("b2b_rd", infifo_read, 1'b1);
        finish_op("b2b", 3, 1, 0);
        consume_op("b2b");

        cur_words = '{64'hAAAA_AAAA_5555_5555, 64'h0BAD_F00D_DEAD_BEEF};
        prep_op(INT32, 0);
        launch();
        tick();
        tick();
        flush = 1'b1;
        #1;
        chk("flush_rd", infifo_read, 1'b0);
        tick();
        flush = 1'b0;
        chk("flush_idle", busy, 1'b0);
        repeat (4) tick();
        chk("flush_reads", nreads, 1);
        chk("flush_novld", valid_seen, 0);
        fifo_q.delete();
        upd_empty();

        for (int i = 0; i < 24; i++) begin
            code = 3'($urandom_range(1, 4));
            n = 4 / (64 / bits_of(code));
            if (n < 1) n = 1;
            cur_words.delete();
            for (int k = 0; k < n; k++) cur_words.push_back({$urandom, $urandom});
            st = (n > 1) ? $urandom_range(0, 2) : 0;
            prep_op(code, st);
            launch();
            finish_op("rand", 1 + 2 * n + st, n, 0);
            hold = $urandom_range(0, 3);
            repeat (hold) tick();
            chk("rand_hold", act_out, model_vec());
            chk("rand_hold_vld", act_valid, 1'b1);
            consume_op("rand");
        end

        cur_words = '{64'h0000_0002_0000_0003, 64'h0000_0004_0000_0005};
        prep_op(INT32, 0);
        launch();
        tick();
        chk("arst_capt_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_act", act_out, '0);
        chk("arst_vld", act_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_err", error, 1'b0);
        chk("arst_rd", infifo_read, 1'b0);
        fifo_q.delete();
        upd_empty();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
